audio_player: RTL and testbench
===============================

# audio_player

Audio note sequencer that sits directly downstream of the CPU control unit. It consumes the `audioreg` (load note), `audioact` (play or adjust) and `s_cont` (adjust tempo) strobes plus the register-file read data. It drives a square wave on the speaker pin and returns `continue`, which tells the control unit when to release the stalled PC. Tone generation is split into a sub-module; the tempo and pitch tables live in a shared package.

## Interface
- `TICK_DIV`, default 50000: clk cycles per base duration tick (1 ms at 50 MHz).
- `TONE_SHIFT`, default 0: right shift applied to every pitch half-period (simulation speed-up).
- `clk` in 1: single system clock; all state updates on rising edge.
- `reset` in 1: synchronous, active-low reset; sampled on rising `clk`.
- `audioreg` in 1: load `data_in` into note register this cycle.
- `audioact` in 1: audio instruction active; held by control unit for the whole instruction.
- `s_cont` in 1: with `audioact`, selects tempo-load instead of play.
- `data_in` in 8: register-file rd2; note = {pitch[7:4], len[3:0]}, or tempo byte.
- `continue` out 1: one-cycle pulse, note finished; control unit advances PC.
- `speaker` out 1: square-wave audio output.
- `busy` out 1: high in PLAY and DONE.

## Operation
- Registers: `note_r`[7:0] and `tempo_r`[7:0]. Latched at play start: `pitch_l`, `total_l` (16 bit).
- `audioreg`=1 → `note_r` <= `data_in`, in any state.
- `audioact`&`s_cont` → `tempo_r` <= `data_in`, in any state; no stall, `continue` unaffected.
- Tick count: `total` = (`tempo_r`+1) × (len==0 ? 16 : len), max 4096. Each tick = `TICK_DIV` cycles.
- Pitch 0 = rest: `speaker` held 0 for the full duration. Pitch 1..15 = C-major scale C4..C6.
- FSM states:
  - IDLE: if `audioact`&!`s_cont` → PLAY. Latch `pitch_l`/`total_l` from `note_r`/`tempo_r`, clear prescaler, tick counter and tone counter.
  - PLAY: prescaler counts 0..`TICK_DIV`-1. At wrap, tick counter increments. When tick counter reaches `total_l`-1 and prescaler wraps → DONE.
  - DONE: `continue`=1 for exactly one cycle → IDLE unconditionally. `audioact` still high here must not retrigger.
- Back-to-back play instructions: the new instruction is sampled in the IDLE cycle after DONE, giving one silent cycle between notes.
- `audioact` dropping in PLAY (not possible from the control unit) aborts to IDLE with `speaker`=0 and no `continue`.
- Tone: half-period = `TONE_HALF[pitch_l]` >> `TONE_SHIFT`, clamped to at least 1. The counter counts up to half-period-1, then toggles `speaker` and clears.

## Timing
- Reset values: `speaker`=0, `continue`=0, `busy`=0, `note_r`=0, `tempo_r`=0, state IDLE, all counters 0.
- Play request sampled at edge k → PLAY from cycle k+1; first `speaker` toggle at cycle k+1+half-period.
- PLAY lasts exactly `total_l` × `TICK_DIV` cycles, then DONE lasts 1 cycle with `continue`=1.
- `speaker` is forced to 0 in IDLE and DONE.
- `audioreg` and a play in the same cycle: the play latches the old `note_r`; the new value takes effect on the next play.
- Reset mid-note: next cycle returns to IDLE, `speaker`=0, no `continue` pulse.

## Configuration
- `AUDIO_GAP_EN`:
  - Defined: `speaker` is forced 0 during the final tick of every note (articulation gap), so repeated identical notes are audibly separated. Duration is unchanged.
  - Undefined: the tone plays for the full duration.

## Structure
- Package `audio_pkg`:
  - State enum (IDLE, PLAY, DONE).
  - `TONE_HALF`[0:15] table of round(25e6/f) values: C4=95556 through C6=23889, entry 0 unused.
  - Field positions `PITCH_MSB`/`LSB` and `LEN_MSB`/`LSB`.
- Sub-module `tone_gen`: inputs `clk`, `reset`, `en`, `clr`, `half`[16:0]; output `sq`.

## Test plan
- After reset: `speaker`=0, `continue`=0, `busy`=0. With `TICK_DIV`=4, `tempo_r`=0, load note 0x12 and hold play → `busy` for 8 cycles, then `continue`=1 for exactly 1 cycle.
- `TONE_SHIFT`=10, pitch 1 (half=93) → `speaker` toggles every 93 cycles. Pitch 15 (half=23) → toggles every 23 cycles.
- Tempo load 0x02 (`audioact`&`s_cont`, single cycle, no `continue`), then play len 0 → PLAY lasts 3×16×4=192 cycles.
- Pitch 0, len 3 → `speaker` stays 0 for 12 cycles, then `continue` pulses.
- Two consecutive play instructions → exactly one IDLE cycle between DONE and the second PLAY. `audioact` held through DONE causes no retrigger.
- Reset deasserted low mid-PLAY → IDLE next cycle, `speaker`=0, no `continue` pulse. With `AUDIO_GAP_EN` defined, `speaker`=0 during the last 4 cycles of each note.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared types and tables for the audio note sequencer: FSM states, note field
// positions, the C-major half-period table and the note duration helper.
package audio_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int PITCH_MSB = 7;
    localparam int PITCH_LSB = 4;
    localparam int LEN_MSB   = 3;
    localparam int LEN_LSB   = 0;

    // round(25e6 / f) in clk cycles at 50 MHz; index 0 is the rest and is never toggled
    localparam logic [16:0] TONE_HALF [0:15] = '{
        17'd0,
        17'd95556, 17'd85131, 17'd75843, 17'd71586, 17'd63776, 17'd56818, 17'd50619,
        17'd47778, 17'd42566, 17'd37922, 17'd35793, 17'd31888, 17'd28409, 17'd25310,
        17'd23889
    };

    function automatic logic [15:0] note_ticks(input logic [7:0] tempo, input logic [3:0] len);
        logic [15:0] mult;
        if (len == 4'd0) begin
            mult = 16'd16;
        end else begin
            mult = {12'd0, len};
        end
        return 16'(({8'd0, tempo} + 16'd1) * mult);
    endfunction

endpackage

// File: rtl/audio_player_tone_gen.sv
// Square-wave generator: toggles sq every `half` enabled cycles; clr forces
// the counter and output low.
module tone_gen (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic        clr,
    input  logic [16:0] half,
    output logic        sq
);

    logic [16:0] cnt_r;

    // Half-period counter and output toggle flop
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_r <= 17'd0;
            sq    <= 1'b0;
        end else if (clr) begin
            cnt_r <= 17'd0;
            sq    <= 1'b0;
        end else if (en) begin
            if (cnt_r >= half - 17'd1) begin
                cnt_r <= 17'd0;
                sq    <= ~sq;
            end else begin
                cnt_r <= cnt_r + 17'd1;
            end
        end
    end

endmodule

// File: rtl/audio_player.sv
// Audio note sequencer downstream of the CPU control unit. Optional build
// macro AUDIO_GAP_EN silences the final tick of every note.
module audio_player
    import audio_pkg::*;
#(
    parameter int TICK_DIV   = 50000,
    parameter int TONE_SHIFT = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       audioreg,
    input  logic       audioact,
    input  logic       s_cont,
    input  logic [7:0] data_in,
    // continue strobe; the plain name is a reserved word
    output logic       cont,
    output logic       speaker,
    output logic       busy
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    state_t         state_r;
    state_t         state_nxt_s;
    logic [7:0]     note_r;
    logic [7:0]     tempo_r;
    logic [3:0]     pitch_l_r;
    logic [15:0]    total_l_r;
    logic [PW-1:0]  presc_r;
    logic [15:0]    tick_r;
    logic [15:0]    tick_nxt_s;
    logic           presc_wrap_s;
    logic           last_tick_s;
    logic           run_s;
    logic [16:0]    half_raw_s;
    logic [16:0]    half_s;

    // Next-state logic and tone-generator run control
    always_comb begin
        state_nxt_s  = state_r;
        presc_wrap_s = (presc_r == PW'(TICK_DIV - 1));
        last_tick_s  = (tick_r == total_l_r - 16'd1);
        run_s        = 1'b0;
        if (presc_wrap_s) begin
            tick_nxt_s = tick_r + 16'd1;
        end else begin
            tick_nxt_s = tick_r;
        end
        case (state_r)
            ST_IDLE: begin
                if (audioact && !s_cont) begin
                    state_nxt_s = ST_PLAY;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_PLAY: begin
                if (!audioact) begin
                    state_nxt_s = ST_IDLE;
                end else if (presc_wrap_s && last_tick_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_PLAY;
                end
            end
            ST_DONE: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
        // Tone only runs while staying in PLAY on a pitched note
        if ((state_r == ST_PLAY) && (state_nxt_s == ST_PLAY) && (pitch_l_r != 4'd0)) begin
`ifdef AUDIO_GAP_EN
            run_s = (tick_nxt_s != total_l_r - 16'd1);
`else
            run_s = 1'b1;
`endif
        end else begin
            run_s = 1'b0;
        end
    end

    // Half-period lookup with speed-up shift, never below one cycle
    always_comb begin
        half_raw_s = TONE_HALF[pitch_l_r] >> TONE_SHIFT;
        if (half_raw_s == 17'd0) begin
            half_s = 17'd1;
        end else begin
            half_s = half_raw_s;
        end
    end

    // State, note/tempo registers, duration counters and status outputs
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r   <= ST_IDLE;
            note_r    <= 8'd0;
            tempo_r   <= 8'd0;
            pitch_l_r <= 4'd0;
            total_l_r <= 16'd0;
            presc_r   <= '0;
            tick_r    <= 16'd0;
            busy      <= 1'b0;
            cont      <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            if (audioreg) begin
                note_r <= data_in;
            end
            if (audioact && s_cont) begin
                tempo_r <= data_in;
            end
            if (state_r == ST_PLAY) begin
                presc_r <= presc_wrap_s ? '0 : presc_r + PW'(1);
                tick_r  <= tick_nxt_s;
            end else begin
                presc_r <= '0;
                tick_r  <= 16'd0;
            end
            // Latch uses the pre-update note_r, so a same-cycle load affects the next play
            if ((state_r == ST_IDLE) && (state_nxt_s == ST_PLAY)) begin
                pitch_l_r <= note_r[PITCH_MSB:PITCH_LSB];
                total_l_r <= note_ticks(tempo_r, note_r[LEN_MSB:LEN_LSB]);
            end
            busy <= (state_nxt_s == ST_PLAY) || (state_nxt_s == ST_DONE);
            cont <= (state_nxt_s == ST_DONE);
        end
    end

    tone_gen u_tone (
        .clk   (clk),
        .reset (reset),
        .en    (run_s),
        .clr   (!run_s),
        .half  (half_s),
        .sq    (speaker)
    );

endmodule

// File: tb/tb_audio_player.sv
// Self-checking bench for audio_player with a note-level reference model
// (durations and tone pattern derived from note frequencies).
module tb_audio_player;

    localparam int TD = 4;
    localparam int TS = 10;
`ifdef AUDIO_GAP_EN
    localparam bit GAP = 1'b1;
`else
    localparam bit GAP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       audioreg = 1'b0;
    logic       audioact = 1'b0;
    logic       s_cont = 1'b0;
    logic [7:0] data_in = 8'd0;
    logic       cont;
    logic       speaker;
    logic       busy;

    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0] m_note  = 8'd0;
    logic [7:0] m_tempo = 8'd0;
    int semis [0:14] = '{0, 2, 4, 5, 7, 9, 11, 12, 14, 16, 17, 19, 21, 23, 24};

    audio_player #(.TICK_DIV(TD), .TONE_SHIFT(TS)) dut (
        .clk      (clk),
        .reset    (reset),
        .audioreg (audioreg),
        .audioact (audioact),
        .s_cont   (s_cont),
        .data_in  (data_in),
        .cont     (cont),
        .speaker  (speaker),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Half period from the equal-tempered frequency of the scale degree
    function automatic int exp_half(input int p);
        real f;
        int  h;
        f = 440.0 * (2.0 ** ((semis[p-1] - 9) / 12.0));
        h = $rtoi(25.0e6 / f + 0.5) >>> TS;
        if (h < 1) h = 1;
        return h;
    endfunction

    function automatic int exp_cycles(input logic [7:0] t, input logic [7:0] nt);
        int len;
        len = (nt[3:0] == 4'd0) ? 16 : int'(nt[3:0]);
        return (int'(t) + 1) * len * TD;
    endfunction

    task automatic load_note(input logic [7:0] v);
        audioreg = 1'b1;
        data_in  = v;
        step();
        audioreg = 1'b0;
        m_note   = v;
    endtask

    task automatic load_tempo(input logic [7:0] v);
        audioact = 1'b1;
        s_cont   = 1'b1;
        data_in  = v;
        step();
        audioact = 1'b0;
        s_cont   = 1'b0;
        m_tempo  = v;
        chk("tempo_cont", cont, 0);
        chk("tempo_busy", busy, 0);
    endtask

    task automatic do_play(input logic [7:0] new_note, input bit load, input bit hold_after);
        logic [7:0] nt;
        int dur, pitch, h, n, e, bad;
        audioact = 1'b1;
        s_cont   = 1'b0;
        nt = m_note;
        if (load) begin
            audioreg = 1'b1;
            data_in  = new_note;
            m_note   = new_note;
        end
        dur   = exp_cycles(m_tempo, nt);
        pitch = int'(nt[7:4]);
        h     = (pitch == 0) ? 1 : exp_half(pitch);
        step();
        audioreg = 1'b0;
        n   = 0;
        bad = 0;
        while (busy === 1'b1 && cont !== 1'b1 && n < 20000) begin
            if (pitch == 0) e = 0;
            else if (GAP && n >= dur - TD) e = 0;
            else e = (n / h) % 2;
            if (speaker !== e[0]) bad++;
            n++;
            step();
        end
        chk("play_len", n, dur);
        chk("spk_pattern", bad, 0);
        chk("cont_pulse", cont, 1);
        step();
        chk("idle_busy", busy, 0);
        chk("idle_cont", cont, 0);
        chk("idle_spk", speaker, 0);
        if (!hold_after) audioact = 1'b0;
    endtask

    initial begin
        int cnt;
        reset = 1'b0;
        repeat (3) step();
        chk("rst_spk", speaker, 0);
        chk("rst_cont", cont, 0);
        chk("rst_busy", busy, 0);
        reset = 1'b1;
        step();

        // Basic note: tempo 0, pitch 1, len 2 -> 8 cycles
        load_note(8'h12);
        do_play(8'h00, 1'b0, 1'b0);
        step();

        // Long pitch 1 and pitch 15 notes to see toggles
        load_tempo(8'h02);
        load_note(8'h10);
        do_play(8'h00, 1'b0, 1'b0);
        load_note(8'hF0);
        do_play(8'h00, 1'b0, 1'b0);

        // Rest note
        load_tempo(8'h00);
        load_note(8'h03);
        do_play(8'h00, 1'b0, 1'b0);

        // Back-to-back with audioact held through DONE; same-cycle load takes effect later
        load_note(8'h54);
        do_play(8'h00, 1'b0, 1'b1);
        do_play(8'hA2, 1'b1, 1'b1);
        do_play(8'h00, 1'b0, 1'b0);
        cnt = 0;
        repeat (4) begin
            step();
            if (busy === 1'b1) cnt++;
        end
        chk("no_retrigger", cnt, 0);

        // Randomized notes
        for (int r = 0; r < 6; r++) begin
            load_tempo(8'($urandom_range(0, 3)));
            load_note(8'($urandom_range(0, 255)));
            do_play(8'h00, 1'b0, 1'b0);
        end

        // Abort by dropping audioact mid-note
        load_note(8'h1F);
        audioact = 1'b1;
        repeat (4) step();
        chk("abort_busy_pre", busy, 1);
        audioact = 1'b0;
        step();
        chk("abort_busy", busy, 0);
        chk("abort_spk", speaker, 0);
        cnt = 0;
        repeat (5) begin
            if (cont === 1'b1) cnt++;
            step();
        end
        chk("abort_cont", cnt, 0);

        // Reset mid-note, then registers back to zero
        load_tempo(8'h01);
        load_note(8'hF8);
        audioact = 1'b1;
        repeat (30) step();
        reset = 1'b0;
        step();
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_spk", speaker, 0);
        reset    = 1'b1;
        audioact = 1'b0;
        cnt = 0;
        repeat (5) begin
            if (cont === 1'b1) cnt++;
            step();
        end
        chk("mid_rst_cont", cnt, 0);
        m_note  = 8'h00;
        m_tempo = 8'h00;
        do_play(8'h00, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
